opfetch_stage: RTL and testbench

- Operand-fetch pipeline stage between decode and execute.
- Drives the register file read selects and captures both operands into an output pipeline register.
- Forwards the same-cycle writeback value around the register file write.
- Keeps a per-register pending-write scoreboard and stalls decode on RAW and WAW hazards.

---
 rtl/opfetch_stage.sv | 89 ++++++++
 tb/tb_opfetch_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/opfetch_stage.sv
// opfetch_stage: operand fetch with writeback forwarding and RAW/WAW scoreboard (optional forwarding via OPFETCH_BYPASS_EN)
module opfetch_stage #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3,
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_asel,
  input  logic [AWIDTH-1:0] in_bsel,
  input  logic [AWIDTH-1:0] in_wsel,
  input  logic              in_wen,
  input  logic [CWIDTH-1:0] in_ctl,
  output logic [AWIDTH-1:0] rf_asel,
  output logic [AWIDTH-1:0] rf_bsel,
  input  logic [DWIDTH-1:0] rf_adata,
  input  logic [DWIDTH-1:0] rf_bdata,
  input  logic              wb_we,
  input  logic [AWIDTH-1:0] wb_wsel,
  input  logic [DWIDTH-1:0] wb_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_a,
  output logic [DWIDTH-1:0] out_b,
  output logic [AWIDTH-1:0] out_wsel,
  output logic              out_wen,
  output logic [CWIDTH-1:0] out_ctl,
  output logic              sb_busy
);
  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0] sb, sb_next, byp_vec, blocked, set_vec, clr_vec;
  logic hazard, accept, fire;

  assign rf_asel = in_asel;
  assign rf_bsel = in_bsel;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
`ifdef OPFETCH_BYPASS_EN
    assign byp_vec[i] = wb_we & (wb_wsel == AWIDTH'(i));
`else
    assign byp_vec[i] = 1'b0;
`endif
    assign blocked[i] = (sb[i] & ~byp_vec[i]) | (out_valid & out_wen & (out_wsel == AWIDTH'(i)));
    assign set_vec[i] = fire & out_wen & (out_wsel == AWIDTH'(i));
    assign clr_vec[i] = wb_we & (wb_wsel == AWIDTH'(i));
  end

  assign hazard   = in_valid & (blocked[in_asel] | blocked[in_bsel] | (in_wen & blocked[in_wsel]));
  assign in_ready = ~hazard & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign sb_next  = (sb & ~clr_vec) | set_vec;

  // output pipeline register: load on accept, drain on fire or flush, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_wsel  <= '0;
      out_wen   <= 1'b0;
      out_ctl   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= byp_vec[in_asel] ? wb_wdata : rf_adata;
      out_b     <= byp_vec[in_bsel] ? wb_wdata : rf_bdata;
      out_wsel  <= in_wsel;
      out_wen   <= in_wen;
      out_ctl   <= in_ctl;
    end else if (fire || flush) begin
      out_valid <= 1'b0;
    end
  end

  // pending-write scoreboard; a set on issue beats a same-cycle writeback clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb      <= '0;
      sb_busy <= 1'b0;
    end else begin
      sb      <= sb_next;
      sb_busy <= |sb_next;
    end
  end
endmodule

// File: tb/tb_opfetch_stage.sv
// tb_opfetch_stage: randomized bench against a behavioural hazard/scoreboard model
module tb_opfetch_stage;
  localparam int DW = 16, AW = 3, CW = 8;

  logic clk, rst_n, in_valid, in_ready, in_wen, wb_we, flush, out_valid, out_ready, out_wen, sb_busy;
  logic [AW-1:0] in_asel, in_bsel, in_wsel, rf_asel, rf_bsel, wb_wsel, out_wsel;
  logic [DW-1:0] rf_adata, rf_bdata, wb_wdata, out_a, out_b;
  logic [CW-1:0] in_ctl, out_ctl;
  logic [DW-1:0] rf [8];

  int checks = 0, errors = 0;

  bit [7:0] msb;
  bit mov, mwen, hold, exp_ready, acc, fir;
  logic [DW-1:0] ma, mb;
  logic [AW-1:0] mwsel;
  logic [CW-1:0] mctl;

  opfetch_stage #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_wsel(in_wsel), .in_wen(in_wen), .in_ctl(in_ctl),
    .rf_asel(rf_asel), .rf_bsel(rf_bsel), .rf_adata(rf_adata), .rf_bdata(rf_bdata),
    .wb_we(wb_we), .wb_wsel(wb_wsel), .wb_wdata(wb_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_wsel(out_wsel), .out_wen(out_wen), .out_ctl(out_ctl), .sb_busy(sb_busy)
  );

  assign rf_adata = rf[rf_asel];
  assign rf_bdata = rf[rf_bsel];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit byp(input logic [AW-1:0] r);
`ifdef OPFETCH_BYPASS_EN
    return wb_we && wb_wsel == r;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit busy(input logic [AW-1:0] r);
    return (msb[r] && !byp(r)) || (mov && mwen && mwsel == r);
  endfunction

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_ctl", out_ctl, 0);
    check("rst_out_wsel", out_wsel, 0);
    check("rst_out_wen", out_wen, 0);
    check("rst_sb_busy", sb_busy, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_asel = 0; in_bsel = 0; in_wsel = 0; in_wen = 0; in_ctl = 0;
    wb_we = 0; wb_wsel = 0; wb_wdata = 0; flush = 0; out_ready = 0;
    for (int i = 0; i < 8; i++) rf[i] = DW'($urandom);
    msb = 0; mov = 0; mwen = 0; ma = 0; mb = 0; mwsel = 0; mctl = 0; hold = 0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (wb_we) rf[wb_wsel] = wb_wdata;
      if (cyc == 2000) begin
        rst_n = 0; in_valid = 0; wb_we = 0; flush = 0;
        #1;
        check_reset_state();
        msb = 0; mov = 0; mwen = 0; ma = 0; mb = 0; mwsel = 0; mctl = 0; hold = 0;
        @(negedge clk);
        rst_n = 1;
        continue;
      end
      if (!hold) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_asel = AW'($urandom_range(0, 7));
        in_bsel = AW'($urandom_range(0, 7));
        in_wsel = AW'($urandom_range(0, 7));
        in_wen = $urandom_range(0, 3) != 0;
        in_ctl = CW'($urandom);
      end
      wb_we = $urandom_range(0, 99) < 40;
      wb_wsel = AW'($urandom_range(0, 7));
      if (msb != 0 && $urandom_range(0, 3) != 0)
        for (int k = 0; k < 32 && !msb[wb_wsel]; k++) wb_wsel = AW'($urandom_range(0, 7));
      wb_wdata = DW'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      #1;
      exp_ready = !(in_valid && (busy(in_asel) || busy(in_bsel) || (in_wen && busy(in_wsel))))
                  && !flush && (!mov || out_ready);
      check("in_ready", in_ready, exp_ready);
      check("rf_asel", rf_asel, in_asel);
      check("rf_bsel", rf_bsel, in_bsel);
      hold = in_valid && !exp_ready;
      acc = in_valid && exp_ready;
      fir = mov && out_ready;
      if (wb_we) msb[wb_wsel] = 0;
      if (fir && mwen) msb[mwsel] = 1;
      if (acc) begin
        ma = byp(in_asel) ? wb_wdata : rf[in_asel];
        mb = byp(in_bsel) ? wb_wdata : rf[in_bsel];
        mwsel = in_wsel; mwen = in_wen; mctl = in_ctl; mov = 1;
      end else if (fir || flush) mov = 0;
      @(posedge clk);
      #1;
      check("out_valid", out_valid, mov);
      if (mov) begin
        check("out_a", out_a, ma);
        check("out_b", out_b, mb);
        check("out_wsel", out_wsel, mwsel);
        check("out_wen", out_wen, mwen);
        check("out_ctl", out_ctl, mctl);
      end
      check("sb_busy", sb_busy, msb != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
